// File: rtl/fft_pkg.sv
// Shared types and constants for the 32-point inverse FFT: sample format,
// FSM states, bit-reversal helper and the inverse-twiddle ROM.
package fft_pkg;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int W     = 16;
    localparam int TW    = 16;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    function automatic logic [4:0] bitrev5(input logic [4:0] k);
        return {k[0], k[1], k[2], k[3], k[4]};
    endfunction

    // W^-k = cos(2*pi*k/32) + j*sin(2*pi*k/32) in Q1.15; unity clipped to 0x7FFF
    function automatic cplx_t twiddle(input logic [3:0] k);
        cplx_t w;
        case (k)
            4'd0:    w = {16'h7FFF, 16'h0000};
            4'd1:    w = {16'h7D8A, 16'h18F9};
            4'd2:    w = {16'h7642, 16'h30FC};
            4'd3:    w = {16'h6A6E, 16'h471D};
            4'd4:    w = {16'h5A82, 16'h5A82};
            4'd5:    w = {16'h471D, 16'h6A6E};
            4'd6:    w = {16'h30FC, 16'h7642};
            4'd7:    w = {16'h18F9, 16'h7D8A};
            4'd8:    w = {16'h0000, 16'h7FFF};
            4'd9:    w = {16'hE707, 16'h7D8A};
            4'd10:   w = {16'hCF04, 16'h7642};
            4'd11:   w = {16'hB8E3, 16'h6A6E};
            4'd12:   w = {16'hA57E, 16'h5A82};
            4'd13:   w = {16'h9592, 16'h471D};
            4'd14:   w = {16'h89BE, 16'h30FC};
            4'd15:   w = {16'h8276, 16'h18F9};
            default: w = {16'h7FFF, 16'h0000};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: t = b*W (>>>15), a' = (a+t)>>>1, b' = (a-t)>>>1.
module fft_butterfly
    import fft_pkg::*;
(
    input  logic [15:0] i_a_re,
    input  logic [15:0] i_a_im,
    input  logic [15:0] i_b_re,
    input  logic [15:0] i_b_im,
    input  logic [15:0] i_w_re,
    input  logic [15:0] i_w_im,
    output logic [15:0] o_a_re,
    output logic [15:0] o_a_im,
    output logic [15:0] o_b_re,
    output logic [15:0] o_b_im
);

    logic signed [31:0] w_br, w_bi, w_wr, w_wi;
    logic signed [31:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [32:0] w_t_re_full, w_t_im_full;
    logic signed [17:0] w_t_re, w_t_im;
    logic signed [18:0] w_a_re, w_a_im, w_tx_re, w_tx_im;
    logic signed [18:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;

    assign w_br = $signed({{16{i_b_re[15]}}, i_b_re});
    assign w_bi = $signed({{16{i_b_im[15]}}, i_b_im});
    assign w_wr = $signed({{16{i_w_re[15]}}, i_w_re});
    assign w_wi = $signed({{16{i_w_im[15]}}, i_w_im});

    assign w_p_rr = w_br * w_wr;
    assign w_p_ii = w_bi * w_wi;
    assign w_p_ri = w_br * w_wi;
    assign w_p_ir = w_bi * w_wr;

    assign w_t_re_full = $signed({w_p_rr[31], w_p_rr}) - $signed({w_p_ii[31], w_p_ii});
    assign w_t_im_full = $signed({w_p_ri[31], w_p_ri}) + $signed({w_p_ir[31], w_p_ir});

    // Truncating >>>15; t is kept at 18 bits since |b*W| can exceed 16 bits
    assign w_t_re = w_t_re_full[32:15];
    assign w_t_im = w_t_im_full[32:15];

    assign w_a_re  = $signed({{3{i_a_re[15]}}, i_a_re});
    assign w_a_im  = $signed({{3{i_a_im[15]}}, i_a_im});
    assign w_tx_re = $signed({w_t_re[17], w_t_re});
    assign w_tx_im = $signed({w_t_im[17], w_t_im});

    assign w_sum_re = w_a_re + w_tx_re;
    assign w_sum_im = w_a_im + w_tx_im;
    assign w_dif_re = w_a_re - w_tx_re;
    assign w_dif_im = w_a_im - w_tx_im;

    assign o_a_re = w_sum_re[16:1];
    assign o_a_im = w_sum_im[16:1];
    assign o_b_re = w_dif_re[16:1];
    assign o_b_im = w_dif_im[16:1];

endmodule

// File: rtl/fft_inv.sv
// 32-point in-place radix-2 inverse FFT: serial bit-reversed load, 80 butterfly
// cycles, then 32 natural-order output samples scaled by 1/32.
module fft_inv
    import fft_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_real_in,
    input  logic [15:0] data_imag_in,
    output logic [15:0] data_real_out,
    output logic [15:0] data_imag_out,
    output logic        all_fft_done
);

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [3:0]  r_bf;
    logic [2:0]  r_stage;
    logic [15:0] r_out_re;
    logic [15:0] r_out_im;
    logic        r_done;
    cplx_t       r_mem [0:31];

    logic [4:0]  w_half, w_mask, w_pos, w_base, w_addr_a, w_addr_b;
    logic [3:0]  w_tw_k;
    cplx_t       w_a, w_b, w_w, w_na, w_nb;

    // Butterfly j of stage s: a = group*2*half + (j mod half), b = a + half
    assign w_half   = 5'd1 << r_stage;
    assign w_mask   = w_half - 5'd1;
    assign w_pos    = {1'b0, r_bf} & w_mask;
    assign w_base   = ({1'b0, r_bf} >> r_stage) << (r_stage + 3'd1);
    assign w_addr_a = w_base | w_pos;
    assign w_addr_b = w_addr_a | w_half;
    assign w_tw_k   = w_pos[3:0] << (3'd4 - r_stage);

    assign w_a = r_mem[w_addr_a];
    assign w_b = r_mem[w_addr_b];
    assign w_w = twiddle(w_tw_k);

    fft_butterfly u_bf (
        .i_a_re (w_a.re),
        .i_a_im (w_a.im),
        .i_b_re (w_b.re),
        .i_b_im (w_b.im),
        .i_w_re (w_w.re),
        .i_w_im (w_w.im),
        .o_a_re (w_na.re),
        .o_a_im (w_na.im),
        .o_b_re (w_nb.re),
        .o_b_im (w_nb.im)
    );

    // Sample memory: bit-reversed loads and in-place butterfly write-back (never cleared)
    always_ff @(posedge clk) begin
        if (r_state == ST_LOAD) begin
            r_mem[bitrev5(r_idx)] <= {data_real_in, data_imag_in};
        end else if (r_state == ST_COMPUTE) begin
            r_mem[w_addr_a] <= w_na;
            r_mem[w_addr_b] <= w_nb;
        end
    end

    // Frame sequencing and registered output stream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_LOAD;
            r_idx    <= 5'd0;
            r_bf     <= 4'd0;
            r_stage  <= 3'd0;
            r_out_re <= 16'd0;
            r_out_im <= 16'd0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_idx <= r_idx + 5'd1;
                    if (r_idx == 5'd31) begin
                        r_state <= ST_COMPUTE;
                        r_bf    <= 4'd0;
                        r_stage <= 3'd0;
                    end
                end
                ST_COMPUTE: begin
                    r_bf <= r_bf + 4'd1;
                    if (r_bf == 4'd15) begin
                        r_stage <= r_stage + 3'd1;
                        // Address 0 is final by now; the last butterfly only touches 15/31
                        if (r_stage == 3'd4) begin
                            r_state  <= ST_OUTPUT;
                            r_done   <= 1'b1;
                            r_out_re <= r_mem[0].re;
                            r_out_im <= r_mem[0].im;
                            r_idx    <= 5'd1;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (r_idx == 5'd0) begin
                        r_state  <= ST_LOAD;
                        r_done   <= 1'b0;
                        r_out_re <= 16'd0;
                        r_out_im <= 16'd0;
                    end else begin
                        r_out_re <= r_mem[r_idx].re;
                        r_out_im <= r_mem[r_idx].im;
                        r_idx    <= r_idx + 5'd1;
                    end
                end
                default: begin
                    r_state  <= ST_LOAD;
                    r_idx    <= 5'd0;
                    r_done   <= 1'b0;
                    r_out_re <= 16'd0;
                    r_out_im <= 16'd0;
                end
            endcase
        end
    end

    assign data_real_out = r_out_re;
    assign data_imag_out = r_out_im;
    assign all_fft_done  = r_done;

endmodule

// File: tb/tb_fft_inv.sv
// Self-checking bench for fft_inv against a floating-point inverse DFT.
module tb_fft_inv;

    localparam real TOL = 8.0;
    localparam real PI  = 3.14159265358979;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_real_in, data_imag_in;
    logic [15:0] data_real_out, data_imag_out;
    logic        all_fft_done;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  x_re [32];
    int  x_im [32];
    int  got_re [32];
    int  got_im [32];
    real ref_re [32];
    real ref_im [32];
    int  lat, dlen;
    bit  tail_ok;

    always #5 clk = ~clk;

    fft_inv dut (
        .clk           (clk),
        .reset         (reset),
        .data_real_in  (data_real_in),
        .data_imag_in  (data_imag_in),
        .data_real_out (data_real_out),
        .data_imag_out (data_imag_out),
        .all_fft_done  (all_fft_done)
    );

    // x[n] = (1/32) * sum_k X[k] * exp(+j*2*pi*k*n/32)
    function automatic void compute_ref();
        for (int n = 0; n < 32; n++) begin
            real sr, si, ang;
            sr = 0.0;
            si = 0.0;
            for (int k = 0; k < 32; k++) begin
                ang = 2.0 * PI * real'(k * n) / 32.0;
                sr += real'(x_re[k]) * $cos(ang) - real'(x_im[k]) * $sin(ang);
                si += real'(x_re[k]) * $sin(ang) + real'(x_im[k]) * $cos(ang);
            end
            ref_re[n] = sr / 32.0;
            ref_im[n] = si / 32.0;
        end
    endfunction

    // Called at a negedge; X[k] is captured by the following posedge.
    task automatic load_frame();
        for (int k = 0; k < 32; k++) begin
            data_real_in = 16'(x_re[k]);
            data_imag_in = 16'(x_im[k]);
            @(negedge clk);
        end
        data_real_in = 16'($urandom);
        data_imag_in = 16'($urandom);
    endtask

    task automatic collect(output int o_lat, output int o_dlen, output bit o_tail_ok);
        o_lat = 0;
        o_dlen = 0;
        o_tail_ok = 1'b0;
        do begin
            @(posedge clk);
            #1;
            o_lat++;
        end while (!all_fft_done && o_lat < 300);
        if (all_fft_done) begin
            for (int n = 0; n < 32; n++) begin
                if (n > 0) begin
                    @(posedge clk);
                    #1;
                end
                got_re[n] = int'($signed(data_real_out));
                got_im[n] = int'($signed(data_imag_out));
                if (all_fft_done) o_dlen++;
            end
            @(posedge clk);
            #1;
            o_tail_ok = !all_fft_done && data_real_out == 16'd0 && data_imag_out == 16'd0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        data_real_in = 16'h1234;
        data_imag_in = 16'h5678;
        repeat (3) @(negedge clk);
        n_tests++;
        if (all_fft_done !== 1'b0 || data_real_out !== 16'd0 || data_imag_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: done=%b re=%h im=%h, expected 0/0000/0000",
                     all_fft_done, data_real_out, data_imag_out);
        end
        reset = 1'b1;
    endtask

    task automatic test_impulse(input string tag);
        for (int k = 0; k < 32; k++) begin
            x_re[k] = 0;
            x_im[k] = 0;
        end
        x_re[0] = 16384;
        load_frame();
        collect(lat, dlen, tail_ok);
        n_tests++;
        if (lat !== 80) begin
            n_fail++;
            $display("FAIL %s latency: %0d edges after X[31], expected 80", tag, lat);
        end
        n_tests++;
        if (dlen !== 32 || !tail_ok) begin
            n_fail++;
            $display("FAIL %s done_window: %0d cycles high, tail_ok=%b, expected 32/1", tag, dlen, tail_ok);
        end
        for (int n = 0; n < 32; n++) begin
            n_tests++;
            if (got_re[n] !== 512 || got_im[n] !== 0) begin
                n_fail++;
                $display("FAIL %s x[%0d]: got %0d j%0d, expected 512 j0", tag, n, got_re[n], got_im[n]);
            end
        end
    endtask

    task automatic test_directed(input int mode, input string tag);
        for (int k = 0; k < 32; k++) begin
            x_re[k] = (mode == 0) ? 2048 : (mode == 1) ? 0 : -32768;
            x_im[k] = (mode == 2) ? -32768 : 0;
        end
        if (mode == 1) x_re[1] = 32767;
        compute_ref();
        load_frame();
        collect(lat, dlen, tail_ok);
        n_tests++;
        if (lat !== 80 || dlen !== 32) begin
            n_fail++;
            $display("FAIL %s timing: latency %0d window %0d, expected 80/32", tag, lat, dlen);
        end
        for (int n = 0; n < 32; n++) begin
            n_tests++;
            if (real'(got_re[n]) - ref_re[n] > TOL || ref_re[n] - real'(got_re[n]) > TOL ||
                real'(got_im[n]) - ref_im[n] > TOL || ref_im[n] - real'(got_im[n]) > TOL) begin
                n_fail++;
                $display("FAIL %s x[%0d]: got %0d j%0d, expected %0.2f j%0.2f", tag, n,
                         got_re[n], got_im[n], ref_re[n], ref_im[n]);
            end
        end
    endtask

    task automatic test_reset_mid_compute();
        for (int k = 0; k < 32; k++) begin
            x_re[k] = int'($urandom_range(32767, 0)) - 16384;
            x_im[k] = int'($urandom_range(32767, 0)) - 16384;
        end
        load_frame();
        repeat (40) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (all_fft_done !== 1'b0 || data_real_out !== 16'd0 || data_imag_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_compute: done=%b re=%h im=%h, expected 0/0000/0000",
                     all_fft_done, data_real_out, data_imag_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_impulse("after_compute_abort");
    endtask

    task automatic test_reset_mid_output();
        int waited;
        for (int k = 0; k < 32; k++) begin
            x_re[k] = 0;
            x_im[k] = 0;
        end
        x_re[0] = 16384;
        load_frame();
        waited = 0;
        while (!all_fft_done && waited < 300) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_tests++;
        if (!all_fft_done) begin
            n_fail++;
            $display("FAIL reset_mid_output: no output window within %0d cycles", waited);
        end
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (all_fft_done !== 1'b0 || data_real_out !== 16'd0 || data_imag_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_output: done=%b re=%h im=%h, expected 0/0000/0000",
                     all_fft_done, data_real_out, data_imag_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_impulse("after_output_abort");
    endtask

    task automatic test_back_to_back(input int frames);
        for (int f = 0; f < frames; f++) begin
            for (int k = 0; k < 32; k++) begin
                x_re[k] = int'($urandom_range(32767, 0)) - 16384;
                x_im[k] = int'($urandom_range(32767, 0)) - 16384;
            end
            compute_ref();
            load_frame();
            collect(lat, dlen, tail_ok);
            n_tests++;
            if (lat !== 80 || dlen !== 32 || !tail_ok) begin
                n_fail++;
                $display("FAIL b2b frame %0d timing: latency %0d window %0d tail_ok %b, expected 80/32/1",
                         f, lat, dlen, tail_ok);
            end
            for (int n = 0; n < 32; n++) begin
                n_tests++;
                if (real'(got_re[n]) - ref_re[n] > TOL || ref_re[n] - real'(got_re[n]) > TOL ||
                    real'(got_im[n]) - ref_im[n] > TOL || ref_im[n] - real'(got_im[n]) > TOL) begin
                    n_fail++;
                    $display("FAIL b2b frame %0d x[%0d]: got %0d j%0d, expected %0.2f j%0.2f", f, n,
                             got_re[n], got_im[n], ref_re[n], ref_im[n]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse("impulse");
        test_directed(0, "constant");
        test_directed(1, "single_bin");
        test_directed(2, "full_scale");
        test_reset_mid_compute();
        test_reset_mid_output();
        test_back_to_back(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
